// File: rtl/mr_issue_ctl_if.sv
`default_nettype none
// ============================================================================
//  Module   : mr_issue_ctl_if
//  Purpose  : Bundles the handshake and status signals between decode,
//             the issue controller, the ALU stage and writeback.
//  Modports : master - driven by the surrounding pipeline (decode/ALU/WB)
//             slave  - seen by mr_issue_ctl
//  Signals  : dec_*     decoded instruction and its ready handshake
//             alu_*     ALU stage input handshake, jmp_done resolve pulse
//             wb_*      writeback retirement of a register write
//             busy_out  per-register pending flag, sb_err sticky underflow,
//             stall_cnt stalled-cycle counter
//  Revision : 1.0 - initial release
// ============================================================================
interface mr_issue_ctl_if #(
    parameter int NREGS   = 32,
    parameter int RSEL    = 5,
    parameter int STALL_W = 32
);
    logic                dec_valid;
    logic                dec_ready;
    logic [RSEL-1:0]     dec_rs1;
    logic [RSEL-1:0]     dec_rs2;
    logic                dec_use_rs1;
    logic                dec_use_rs2;
    logic [RSEL-1:0]     dec_rd;
    logic                dec_is_br;
    logic                alu_valid;
    logic                alu_ready;
    logic                jmp_done;
    logic                wb_valid;
    logic [RSEL-1:0]     wb_reg;
    logic [NREGS-1:0]    busy_out;
    logic                sb_err;
    logic [STALL_W-1:0]  stall_cnt;

    modport master (
        output dec_valid, dec_rs1, dec_rs2, dec_use_rs1, dec_use_rs2,
               dec_rd, dec_is_br, alu_ready, jmp_done, wb_valid, wb_reg,
        input  dec_ready, alu_valid, busy_out, sb_err, stall_cnt
    );

    modport slave (
        input  dec_valid, dec_rs1, dec_rs2, dec_use_rs1, dec_use_rs2,
               dec_rd, dec_is_br, alu_ready, jmp_done, wb_valid, wb_reg,
        output dec_ready, alu_valid, busy_out, sb_err, stall_cnt
    );
endinterface
`default_nettype wire

// File: rtl/mr_issue_ctl.sv
`default_nettype none
// ============================================================================
//  Module   : mr_issue_ctl
//  Purpose  : Issue controller between decode and the ALU. A per-register
//             pending-write scoreboard blocks RAW hazards until writeback
//             retires the producer; branches/jumps serialise issue until the
//             ALU signals resolution. Counts stalled cycles and flags
//             scoreboard underflow.
//  Ports    : clk, rst (synchronous, active high)
//             bus  - mr_issue_ctl_if.slave (decode, ALU, writeback, status)
//  Revision : 1.0 - initial release
// ============================================================================
module mr_issue_ctl #(
    parameter int NREGS   = 32,
    parameter int RSEL    = 5,
    parameter int PCNT_W  = 2,
    parameter int STALL_W = 32
) (
    input  wire logic          clk,
    input  wire logic          rst,
    mr_issue_ctl_if.slave      bus
);

    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_BR_WAIT = 1'b1
    } state_t;

    localparam logic [PCNT_W-1:0] C_PEND_MAX = '1;

    state_t              state_q;
    logic [PCNT_W-1:0]   pend_q [NREGS];
    logic [PCNT_W-1:0]   pend_d [NREGS];
    logic                sb_err_q;
    logic [STALL_W-1:0]  stall_q;

    logic w_rs1_haz;
    logic w_rs2_haz;
    logic w_rd_haz;
    logic w_hazard;
    logic w_run;
    logic w_alu_valid;
    logic w_dec_ready;
    logic w_fire;
    logic w_stall;
    logic w_underflow;

    // Issue gating: source operands must have no pending write, and the
    // destination counter must have headroom so it can never wrap.
    always_comb begin
        w_rs1_haz   = bus.dec_use_rs1 && (bus.dec_rs1 != '0) && (pend_q[bus.dec_rs1] != '0);
        w_rs2_haz   = bus.dec_use_rs2 && (bus.dec_rs2 != '0) && (pend_q[bus.dec_rs2] != '0);
        w_rd_haz    = (bus.dec_rd != '0) && (pend_q[bus.dec_rd] == C_PEND_MAX);
        w_hazard    = w_rs1_haz || w_rs2_haz || w_rd_haz;
        w_run       = (state_q == ST_RUN);
        w_alu_valid = bus.dec_valid && !w_hazard && w_run;
        w_dec_ready = bus.alu_ready && !w_hazard && w_run;
        w_fire      = w_alu_valid && bus.alu_ready;
        w_stall     = bus.dec_valid && !w_dec_ready;
        w_underflow = bus.wb_valid && (bus.wb_reg != '0) && (pend_q[bus.wb_reg] == '0);
    end

    // Next pending counts. Register 0 is never tracked. A writeback on a
    // zero count is not applied (it is reported through sb_err instead).
    always_comb begin
        pend_d[0] = '0;
        for (int r = 1; r < NREGS; r++) begin
            pend_d[r] = pend_q[r];
            case ({w_fire && (bus.dec_rd == RSEL'(r)),
                   bus.wb_valid && (bus.wb_reg == RSEL'(r)) && (pend_q[r] != '0)})
                2'b10:   pend_d[r] = pend_q[r] + PCNT_W'(1);
                2'b01:   pend_d[r] = pend_q[r] - PCNT_W'(1);
                default: pend_d[r] = pend_q[r];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_RUN;
            sb_err_q <= 1'b0;
            stall_q  <= '0;
            for (int r = 0; r < NREGS; r++) begin
                pend_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                pend_q[r] <= pend_d[r];
            end
            case (state_q)
                ST_RUN:     if (w_fire && bus.dec_is_br) state_q <= ST_BR_WAIT;
                ST_BR_WAIT: if (bus.jmp_done)            state_q <= ST_RUN;
                default:                                 state_q <= ST_RUN;
            endcase
            if (w_underflow) sb_err_q <= 1'b1;
            if (w_stall)     stall_q  <= stall_q + STALL_W'(1);
        end
    end

    assign bus.alu_valid = w_alu_valid;
    assign bus.dec_ready = w_dec_ready;
    assign bus.sb_err    = sb_err_q;
    assign bus.stall_cnt = stall_q;

    // Debug view derived purely from registered counts.
    for (genvar i = 0; i < NREGS; i++) begin : g_busy
        assign bus.busy_out[i] = (pend_q[i] != '0);
    end

endmodule
`default_nettype wire

// File: tb/tb_mr_issue_ctl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mr_issue_ctl
//  Purpose  : Self-checking bench for mr_issue_ctl. Directed per-cycle
//             vectors with hand-computed expectations, plus a hand-written
//             writeback-to-issue latency sequence.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mr_issue_ctl;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    mr_issue_ctl_if #(.NREGS(32), .RSEL(5), .STALL_W(32)) bus ();

    mr_issue_ctl #(
        .NREGS   (32),
        .RSEL    (5),
        .PCNT_W  (2),
        .STALL_W (32)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit        rst;
        bit        dv;
        bit [4:0]  rs1;
        bit        u1;
        bit [4:0]  rs2;
        bit        u2;
        bit [4:0]  rd;
        bit        br;
        bit        ar;
        bit        jd;
        bit        wv;
        bit [4:0]  wr;
        bit        eav;
        bit        edr;
        bit [31:0] ebusy;
        bit        eerr;
        bit [31:0] estall;
    } vec_t;

    function automatic vec_t mk(bit rst_v, bit dv, bit [4:0] rs1, bit u1,
                                bit [4:0] rs2, bit u2, bit [4:0] rd, bit br,
                                bit ar, bit jd, bit wv, bit [4:0] wr,
                                bit eav, bit edr, bit [31:0] ebusy,
                                bit eerr, bit [31:0] estall);
        vec_t v;
        v.rst = rst_v; v.dv = dv; v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2;
        v.u2 = u2; v.rd = rd; v.br = br; v.ar = ar; v.jd = jd; v.wv = wv;
        v.wr = wr; v.eav = eav; v.edr = edr; v.ebusy = ebusy;
        v.eerr = eerr; v.estall = estall;
        return v;
    endfunction

    function automatic bit [31:0] bm(int n);
        bit [31:0] one;
        one = 32'h1;
        return one << n;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit rst_v, input bit dv, input bit [4:0] rs1, input bit u1,
                         input bit [4:0] rs2, input bit u2, input bit [4:0] rd,
                         input bit br, input bit ar, input bit jd,
                         input bit wv, input bit [4:0] wr);
        rst             = rst_v;
        bus.dec_valid   = dv;
        bus.dec_rs1     = rs1;
        bus.dec_use_rs1 = u1;
        bus.dec_rs2     = rs2;
        bus.dec_use_rs2 = u2;
        bus.dec_rd      = rd;
        bus.dec_is_br   = br;
        bus.alu_ready   = ar;
        bus.jmp_done    = jd;
        bus.wb_valid    = wv;
        bus.wb_reg      = wr;
    endtask

    vec_t tbl[$];

    initial begin
        int n;
        checks   = 0;
        failures = 0;

        drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        repeat (2) @(posedge clk);

        // rst dv  rs1 u1 rs2 u2 rd br ar jd wv wr | av dr busy     err stall
        // reset state
        tbl.push_back(mk(0,0, 0,0, 0,0, 0,0,1,0,0, 0,  0,1,32'h0,  0,0));
        // RAW on r5, writeback then issue the following cycle
        tbl.push_back(mk(0,1, 0,0, 0,0, 5,0,1,0,0, 0,  1,1,32'h0,  0,0));
        tbl.push_back(mk(0,1, 5,1, 0,0, 6,0,1,0,0, 0,  0,0,bm(5),  0,0));
        tbl.push_back(mk(0,1, 5,1, 0,0, 6,0,1,0,1, 5,  0,0,bm(5),  0,1));
        tbl.push_back(mk(0,1, 5,1, 0,0, 6,0,1,0,0, 0,  1,1,32'h0,  0,2));
        tbl.push_back(mk(0,0, 0,0, 0,0, 0,0,1,0,1, 6,  0,1,bm(6),  0,2));
        // register 0 never tracked
        tbl.push_back(mk(0,1, 0,0, 0,0, 0,0,1,0,0, 0,  1,1,32'h0,  0,2));
        tbl.push_back(mk(0,1, 0,1, 0,1, 0,0,1,0,0, 0,  1,1,32'h0,  0,2));
        tbl.push_back(mk(0,0, 0,0, 0,0, 0,0,1,0,1, 0,  0,1,32'h0,  0,2));
        tbl.push_back(mk(0,0, 0,0, 0,0, 0,0,1,0,0, 0,  0,1,32'h0,  0,2));
        // saturate r7 at 3, fourth write stalls
        tbl.push_back(mk(0,1, 0,0, 0,0, 7,0,1,0,0, 0,  1,1,32'h0,  0,2));
        tbl.push_back(mk(0,1, 0,0, 0,0, 7,0,1,0,0, 0,  1,1,bm(7),  0,2));
        tbl.push_back(mk(0,1, 0,0, 0,0, 7,0,1,0,0, 0,  1,1,bm(7),  0,2));
        tbl.push_back(mk(0,1, 0,0, 0,0, 7,0,1,0,0, 0,  0,0,bm(7),  0,2));
        // wb while saturated: still stalled, count drops to 2
        tbl.push_back(mk(0,1, 0,0, 0,0, 7,0,1,0,1, 7,  0,0,bm(7),  0,3));
        // issue + wb same cycle: count stays 2, so one more fits, then stall
        tbl.push_back(mk(0,1, 0,0, 0,0, 7,0,1,0,1, 7,  1,1,bm(7),  0,4));
        tbl.push_back(mk(0,1, 0,0, 0,0, 7,0,1,0,0, 0,  1,1,bm(7),  0,4));
        tbl.push_back(mk(0,1, 0,0, 0,0, 7,0,1,0,0, 0,  0,0,bm(7),  0,4));
        // drain r7
        tbl.push_back(mk(0,0, 0,0, 0,0, 0,0,1,0,1, 7,  0,1,bm(7),  0,5));
        tbl.push_back(mk(0,0, 0,0, 0,0, 0,0,1,0,1, 7,  0,1,bm(7),  0,5));
        tbl.push_back(mk(0,0, 0,0, 0,0, 0,0,1,0,1, 7,  0,1,bm(7),  0,5));
        tbl.push_back(mk(0,0, 0,0, 0,0, 0,0,1,0,0, 0,  0,1,32'h0,  0,5));
        // underflow on r9 is sticky and leaves r9 idle
        tbl.push_back(mk(0,0, 0,0, 0,0, 0,0,1,0,1, 9,  0,1,32'h0,  0,5));
        tbl.push_back(mk(0,0, 0,0, 0,0, 0,0,1,0,0, 0,  0,1,32'h0,  1,5));
        tbl.push_back(mk(0,0, 0,0, 0,0, 0,0,1,0,0, 0,  0,1,32'h0,  1,5));
        // branch serialisation, jmp_done in RUN ignored
        tbl.push_back(mk(0,1, 0,0, 0,0, 0,1,1,0,0, 0,  1,1,32'h0,  1,5));
        tbl.push_back(mk(0,1, 0,0, 0,0, 0,0,1,1,0, 0,  0,0,32'h0,  1,5));
        tbl.push_back(mk(0,1, 0,0, 0,0, 0,0,1,0,0, 0,  1,1,32'h0,  1,6));
        tbl.push_back(mk(0,0, 0,0, 0,0, 0,0,1,1,0, 0,  0,1,32'h0,  1,6));
        tbl.push_back(mk(0,1, 0,0, 0,0, 0,0,1,0,0, 0,  1,1,32'h0,  1,6));
        // alu_ready low stalls and counts
        tbl.push_back(mk(0,1, 0,0, 0,0, 0,0,0,0,0, 0,  1,0,32'h0,  1,6));
        tbl.push_back(mk(0,1, 0,0, 0,0, 0,0,1,0,0, 0,  1,1,32'h0,  1,7));
        // r3 pending 2 via plain write + jal, then sit in BR_WAIT
        tbl.push_back(mk(0,1, 0,0, 0,0, 3,0,1,0,0, 0,  1,1,32'h0,  1,7));
        tbl.push_back(mk(0,1, 0,0, 0,0, 3,1,1,0,0, 0,  1,1,bm(3),  1,7));
        tbl.push_back(mk(0,1, 3,1, 0,0, 0,0,1,0,0, 0,  0,0,bm(3),  1,7));
        // reset mid-flight; wb/jmp_done during reset ignored
        tbl.push_back(mk(1,1, 3,1, 0,0, 0,0,1,1,1, 9,  0,0,bm(3),  1,8));
        tbl.push_back(mk(0,1, 3,1, 0,0, 0,0,1,0,0, 0,  1,1,32'h0,  0,0));
        tbl.push_back(mk(0,0, 0,0, 0,0, 0,0,1,0,0, 0,  0,1,32'h0,  0,0));

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i].rst, tbl[i].dv, tbl[i].rs1, tbl[i].u1, tbl[i].rs2, tbl[i].u2,
                  tbl[i].rd, tbl[i].br, tbl[i].ar, tbl[i].jd, tbl[i].wv, tbl[i].wr);
            #2;
            check($sformatf("v%0d alu_valid", i), 32'(bus.alu_valid), 32'(tbl[i].eav));
            check($sformatf("v%0d dec_ready", i), 32'(bus.dec_ready), 32'(tbl[i].edr));
            check($sformatf("v%0d busy_out", i),  bus.busy_out,       tbl[i].ebusy);
            check($sformatf("v%0d sb_err", i),    32'(bus.sb_err),    32'(tbl[i].eerr));
            check($sformatf("v%0d stall_cnt", i), bus.stall_cnt,      tbl[i].estall);
        end

        // Writeback-to-issue latency on r10 with a rs2 dependency.
        @(negedge clk);
        drive(0, 1, 0, 0, 0, 0, 10, 0, 1, 0, 0, 0);
        #2;
        check("seq producer issue", 32'(bus.alu_valid), 32'd1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive(0, 1, 0, 0, 10, 1, 0, 0, 1, 0, (k == 3), 10);
            #2;
            check($sformatf("seq hold %0d", k), 32'(bus.alu_valid), 32'd0);
        end
        n = 0;
        for (int w = 0; w < 8; w++) begin
            @(negedge clk);
            drive(0, 1, 0, 0, 10, 1, 0, 0, 1, 0, 0, 0);
            #2;
            if (bus.alu_valid === 1'b1) break;
            n++;
        end
        check("seq fire latency", 32'(n), 32'd0);
        check("seq stall_cnt", bus.stall_cnt, 32'd4);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        #2;
        check("seq busy cleared", bus.busy_out, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
